ide_mgmt_arbiter: RTL

- Sequences host (IO-controller) service of the two Gayle IDE ports through their shared 5-bit management port.
- Watches the 6-bit IDE request vector and grants one port at a time, round-robin or fixed priority.
- Exposes a single request/ack interface to the host, then forwards the host's management reads and writes to the granted port only.
- Includes a watchdog that releases a grant if the host stalls.

---
 rtl/ide_mgmt_arbiter_if.sv | 41 ++++
 rtl/ide_mgmt_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/ide_mgmt_arbiter_if.sv
// ide_mgmt_arbiter_if: bundles the IDE request vector, the Gayle management port and the
// host request/ack interface of ide_mgmt_arbiter.
//   slave  : arbiter side (samples requests and host strobes, drives mgmt port and host status)
//   master : environment side (IDE core, Gayle and host controller)
// Signals:
//   ide_req        [2:0] port 0 request code, [5:3] port 1 request code
//   mgmt_address   {granted port, host register address}
//   mgmt_write/mgmt_read/mgmt_writedata/mgmt_readdata  Gayle management access
//   host_irq/host_port/host_code  grant status presented to the host
//   host_addr/host_write/host_wdata/host_read/host_rdata/host_done  host access and completion
//   timeout        single-cycle watchdog expiry pulse
interface ide_mgmt_arbiter_if;
    logic [5:0]  ide_req;
    logic [4:0]  mgmt_address;
    logic        mgmt_write;
    logic [15:0] mgmt_writedata;
    logic        mgmt_read;
    logic [15:0] mgmt_readdata;
    logic        host_irq;
    logic        host_port;
    logic [2:0]  host_code;
    logic [3:0]  host_addr;
    logic        host_write;
    logic [15:0] host_wdata;
    logic        host_read;
    logic [15:0] host_rdata;
    logic        host_done;
    logic        timeout;

    modport slave (
        input  ide_req, mgmt_readdata, host_addr, host_write, host_wdata, host_read, host_done,
        output mgmt_address, mgmt_write, mgmt_writedata, mgmt_read, host_irq, host_port,
               host_code, host_rdata, timeout
    );

    modport master (
        output ide_req, mgmt_readdata, host_addr, host_write, host_wdata, host_read, host_done,
        input  mgmt_address, mgmt_write, mgmt_writedata, mgmt_read, host_irq, host_port,
               host_code, host_rdata, timeout
    );
endinterface

// File: rtl/ide_mgmt_arbiter.sv
// ide_mgmt_arbiter: grants one of the two Gayle IDE ports to the host at a time and forwards the
// host's management reads/writes to the granted port through the shared 5-bit management port.
// A watchdog releases the grant when the host stops accessing the port.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    ide_mgmt_arbiter_if.slave (IDE requests, Gayle management port, host interface)
// Parameters:
//   TIMEOUT_W  watchdog width; expiry after 2^TIMEOUT_W-1 consecutive cycles without access
//   FAIR       1: alternate ports on a tie; 0: port 0 always wins a tie
//   HOLD       cycles spent releasing before arbitrating again
module ide_mgmt_arbiter #(
    parameter int unsigned TIMEOUT_W = 20,
    parameter bit          FAIR      = 1'b1,
    parameter int unsigned HOLD      = 2
) (
    input logic               clk,
    input logic               reset,
    ide_mgmt_arbiter_if.slave bus
);

    localparam int unsigned HoldW    = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int unsigned HoldLast = (HOLD > 0) ? HOLD - 1 : 0;
    // The cycle that would carry the count to all-ones is the expiring one.
    localparam logic [TIMEOUT_W-1:0] WdLast = ~TIMEOUT_W'(1);

    typedef enum logic [1:0] {StIdle, StServe, StRelease} state_e;

    state_e               state_q;
    logic                 last_q;
    logic                 host_irq_q;
    logic                 host_port_q;
    logic [2:0]           host_code_q;
    logic                 timeout_q;
    logic [TIMEOUT_W-1:0] wd_q;
    logic [HoldW-1:0]     hold_q;

    logic want0, want1, grant_port, access, serve;

    always_comb begin
        want0  = |bus.ide_req[2:0];
        want1  = |bus.ide_req[5:3];
        access = bus.host_read | bus.host_write;
        if (want0 && want1) begin
            grant_port = FAIR ? ~last_q : 1'b0;
        end else begin
            grant_port = want1;
        end
        // Gating with reset drops any in-flight strobe in the cycle reset is sampled.
        serve = (state_q == StServe) && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            last_q      <= 1'b1;
            host_irq_q  <= 1'b0;
            host_port_q <= 1'b0;
            host_code_q <= 3'd0;
            timeout_q   <= 1'b0;
            wd_q        <= '0;
            hold_q      <= '0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (want0 || want1) begin
                        state_q     <= StServe;
                        host_irq_q  <= 1'b1;
                        host_port_q <= grant_port;
                        host_code_q <= grant_port ? bus.ide_req[5:3] : bus.ide_req[2:0];
                        wd_q        <= '0;
                    end
                end
                StServe: begin
                    if (bus.host_done || (!access && wd_q == WdLast)) begin
                        state_q    <= StRelease;
                        host_irq_q <= 1'b0;
                        last_q     <= host_port_q;
                        wd_q       <= '0;
                        hold_q     <= '0;
                        // A completion in the expiry cycle wins: no timeout pulse.
                        timeout_q  <= !bus.host_done;
                    end else if (access) begin
                        wd_q <= '0;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                StRelease: begin
                    if (hold_q == HoldW'(HoldLast)) begin
                        state_q <= StIdle;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.host_irq       = host_irq_q;
    assign bus.host_port      = host_port_q;
    assign bus.host_code      = host_code_q;
    assign bus.timeout        = timeout_q;
    assign bus.mgmt_address   = {host_port_q, serve ? bus.host_addr : 4'h0};
    assign bus.mgmt_writedata = bus.host_wdata;
    assign bus.mgmt_write     = serve & bus.host_write;
    assign bus.mgmt_read      = serve & bus.host_read & ~bus.host_write;
    assign bus.host_rdata     = serve ? bus.mgmt_readdata : 16'h0;

endmodule
